sub_serial_n: RTL and testbench

- Bit-serial n-bit subtractor computing data0_i - data1_i, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow.
- Companion to the serial adder in the arithmetic library; forms the subtract path of the bai4 serial ALU.
- Start/done handshake; result and flags held until the next operation.

---
 rtl/sub_serial_n_pkg.sv | 18 +
 rtl/sub_serial_n_fs_1bit.sv | 14 +
 rtl/sub_serial_n.sv | 104 ++++++++++
 tb/tb_sub_serial_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_n_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM encoding and counter sizing.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned N_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT = $clog2(N_DEFAULT);

    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sub_serial_n_fs_1bit.sv
// One-bit full subtractor cell: d = a - b - bin.
// Borrow-out follows the textbook ripple form.
module fs_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub_serial_n.sv
// Bit-serial n-bit subtractor, LSB first, one bit per clock.
// Start/done handshake; result and flags held until the next done.
module sub_serial_n
    import sub_serial_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [n-1:0] data0_i,
    input  logic [n-1:0] data1_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [n-1:0] diff_o,
    output logic         borrow_o,
    output logic         ovf_o
);

    localparam int CW = cnt_w(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  a_q;
    logic [n-1:0]  b_q;
    logic [n-1:0]  r_q;
    logic [n-1:0]  r_d;
    logic [n-1:0]  diff_q;
    logic          bin_q;
    logic          borrow_q;
    logic          ovf_q;
    logic          a_msb_q;
    logic          b_msb_q;
    logic          fs_d;
    logic          fs_bout;

    fs_1bit u_fs (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .bin_i (bin_q),
        .d_o   (fs_d),
        .bout_o(fs_bout)
    );

    assign r_d = {fs_d, r_q[n-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= data0_i;
                        b_q     <= data1_i;
                        a_msb_q <= data0_i[n-1];
                        b_msb_q <= data1_i[n-1];
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_q   <= r_d;
                    a_q   <= {1'b0, a_q[n-1:1]};
                    b_q   <= {1'b0, b_q[n-1:1]};
                    bin_q <= fs_bout;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // fs_d is the final (MSB) difference bit here
                        diff_q   <= r_d;
                        borrow_q <= fs_bout;
                        ovf_q    <= (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_sub_serial_n.sv
// Directed self-checking bench for sub_serial_n (n=8).
// Expected values are hand-computed constants.
module tb_sub_serial_n;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int pulses;

    sub_serial_n #(.n(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .data0_i (d0),
        .data1_i (d1),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .borrow_o(borrow),
        .ovf_o   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accepting edge until done_o, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ed,
                          input logic eb, input logic eo);
        int e;
        d0    = a;
        d1    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        d0    = 8'hxx;
        d1    = 8'hxx;
        check({tag, "_busy"}, 16'(busy), 16'd1);
        wait_done(e);
        check({tag, "_lat"}, 16'(e), 16'd8);
        check({tag, "_diff"}, 16'(diff), 16'(ed));
        check({tag, "_brw"}, 16'(borrow), 16'(eb));
        check({tag, "_ovf"}, 16'(ovf), 16'(eo));
        tick();
        check({tag, "_done_off"}, {14'd0, busy, done}, 16'd0);
    endtask

    initial begin
        int e;
        rst_n = 1'b0;
        start = 1'b0;
        d0    = 8'h00;
        d1    = 8'h00;
        #1;
        check("rst_out", {busy, done, diff, borrow, ovf}, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_out", {busy, done, diff, borrow, ovf}, 16'd0);

        run_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t2", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // start held high across two operations
        d0    = 8'h7F;
        d1    = 8'hFF;
        start = 1'b1;
        tick();
        d0 = 8'h10;
        d1 = 8'h10;
        wait_done(e);
        check("t4_lat", 16'(e), 16'd8);
        check("t4_diff", 16'(diff), 16'h80);
        check("t4_brw", 16'(borrow), 16'd1);
        check("t4_ovf", 16'(ovf), 16'd1);
        tick();
        check("t4_idle", {14'd0, busy, done}, 16'd0);
        tick();
        check("t4b_acc", 16'(busy), 16'd1);
        start = 1'b0;
        tick();
        check("t4_hold", {7'd0, diff, borrow}, {7'd0, 8'h80, 1'b1});
        wait_done(e);
        check("t4b_lat", 16'(e), 16'd7);
        check("t4b_diff", 16'(diff), 16'h00);
        check("t4b_flags", {14'd0, borrow, ovf}, 16'd0);
        tick();

        // second start mid-SHIFT is ignored
        d0    = 8'h55;
        d1    = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        d0    = 8'hFF;
        d1    = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 3;
        while (!done && e < 20) begin
            tick();
            e++;
        end
        check("t5_lat", 16'(e), 16'd8);
        check("t5_diff", 16'(diff), 16'h33);
        check("t5_flags", {14'd0, borrow, ovf}, 16'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check("t5_pulses", 16'(pulses), 16'd0);
        check("t5_busy", 16'(busy), 16'd0);

        // reset during SHIFT aborts the operation
        d0    = 8'h12;
        d1    = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst", {busy, done, diff, borrow, ovf}, 16'd0);
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("t6_nodone", 16'(pulses), 16'd0);
        run_op("t6b", 8'h0A, 8'h0B, 8'hFF, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
